// File: rtl/multiplexor_arbitrado_if.sv
`default_nettype none
// ============================================================================
// Module   : multiplexor_arbitrado_if
// Brief    : Handshake bundle between N producers, the arbitrated mux and
//            the single consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface multiplexor_arbitrado_if #(
  parameter int BITS    = 32,
  parameter int CANALES = 16
);
  localparam int SEL_W = $clog2(CANALES);

  logic [CANALES*BITS-1:0] datoIn;
  logic [CANALES-1:0]      validIn;
  logic [CANALES-1:0]      readyIn;
  logic                    modo;
  logic [SEL_W-1:0]        selDato;
  logic [BITS-1:0]         datoOutput;
  logic                    validOut;
  logic                    readyOut;
  logic [SEL_W-1:0]        canalOut;

  // Producer/consumer side of the bundle
  modport master (
    output datoIn, validIn, modo, selDato, readyOut,
    input  readyIn, datoOutput, validOut, canalOut
  );

  // Multiplexer side of the bundle
  modport slave (
    input  datoIn, validIn, modo, selDato, readyOut,
    output readyIn, datoOutput, validOut, canalOut
  );
endinterface
`default_nettype wire

// File: rtl/multiplexor_arbitrado.sv
`default_nettype none
// ============================================================================
// Module   : multiplexor_arbitrado
// Brief    : N-channel registered multiplexer, fixed-index or round-robin
//            selection, valid/ready on every input and on the output.
// Revision : 1.0 - initial release
// ============================================================================
module multiplexor_arbitrado #(
  parameter int BITS    = 32,
  parameter int CANALES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  multiplexor_arbitrado_if.slave bus
);
  localparam int SEL_W     = $clog2(CANALES);
  localparam int c_num_idx = 1 << SEL_W;
  localparam logic [SEL_W:0]   c_canales = (SEL_W+1)'(CANALES);
  localparam logic [SEL_W-1:0] c_ptr_ini = SEL_W'(CANALES-1);

  typedef enum logic [0:0] {
    VACIO = 1'b0,
    LLENO = 1'b1
  } estado_t;

  estado_t r_estado;
  estado_t w_estado_sig;

  logic [c_num_idx-1:0] w_valid_ext;
  logic [BITS-1:0]      w_dato_arr [c_num_idx];
  logic [SEL_W-1:0]     r_ptr;
  logic [SEL_W-1:0]     w_rr_gnt;
  logic                 w_rr_hay;
  logic [SEL_W:0]       w_cand;
  logic                 w_fijo_hay;
  logic [SEL_W-1:0]     w_gnt;
  logic                 w_hay;
  logic                 w_carga;
  logic                 w_carga_en;
  logic [c_num_idx-1:0] w_ready_ext;
  logic [BITS-1:0]      r_dato;
  logic [SEL_W-1:0]     r_canal;

  // Pad the channel set to a power of two so every index code is addressable;
  // padded slots never request, so they can never be granted.
  for (genvar k = 0; k < c_num_idx; k++) begin : g_canal
    if (k < CANALES) begin : g_real
      assign w_valid_ext[k] = bus.validIn[k];
      assign w_dato_arr[k]  = bus.datoIn[k*BITS +: BITS];
    end else begin : g_relleno
      assign w_valid_ext[k] = 1'b0;
      assign w_dato_arr[k]  = '0;
    end
  end

  // Walk from farthest to nearest so the closest requester after ptr wins.
  always_comb begin
    w_rr_gnt = '0;
    w_rr_hay = 1'b0;
    w_cand   = '0;
    for (int i = CANALES; i >= 1; i--) begin
      w_cand = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (w_cand >= c_canales) begin
        w_cand = w_cand - c_canales;
      end
      if (w_valid_ext[w_cand[SEL_W-1:0]]) begin
        w_rr_gnt = w_cand[SEL_W-1:0];
        w_rr_hay = 1'b1;
      end
    end
  end

  assign w_fijo_hay = ({1'b0, bus.selDato} < c_canales) && w_valid_ext[bus.selDato];
  assign w_gnt      = bus.modo ? w_rr_gnt : bus.selDato;
  assign w_hay      = bus.modo ? w_rr_hay : w_fijo_hay;
  assign w_carga    = (r_estado == VACIO) | bus.readyOut;
  assign w_carga_en = w_carga & w_hay;

  always_comb begin
    w_ready_ext = '0;
    if (w_carga_en) begin
      w_ready_ext[w_gnt] = 1'b1;
    end
  end

  assign bus.readyIn = w_ready_ext[CANALES-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= VACIO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      VACIO: begin
        if (w_carga_en) begin
          w_estado_sig = LLENO;
        end
      end
      LLENO: begin
        if (!w_carga_en && bus.readyOut) begin
          w_estado_sig = VACIO;
        end
      end
      default: begin
        w_estado_sig = VACIO;
      end
    endcase
  end

  // Pointer only advances on round-robin loads; fixed-mode loads leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dato  <= '0;
      r_canal <= '0;
      r_ptr   <= c_ptr_ini;
    end else if (w_carga_en) begin
      r_dato  <= w_dato_arr[w_gnt];
      r_canal <= w_gnt;
      if (bus.modo) begin
        r_ptr <= w_gnt;
      end
    end
  end

  assign bus.datoOutput = r_dato;
  assign bus.validOut   = (r_estado == LLENO);
  assign bus.canalOut   = r_canal;

endmodule
`default_nettype wire

// File: doc/multiplexor_arbitrado.md
Name: multiplexor_arbitrado

Overview:
Parametrised N-channel registered multiplexer with valid/ready handshake on every input and on the output. It has two selection modes: fixed selection by index, or round-robin arbitration among requesting channels. It feeds shared datapath resources (register-file write port, memory bus, video/sprite bus) from several producers. It replaces chains of fixed-width combinational muxes wherever producers must be arbitrated and the result registered.

Parameters:
BITS, 32, data width per channel
CANALES, 16, number of input channels (2..64)
SEL_W, $clog2(CANALES), width of channel index (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
datoIn  input  CANALES*BITS  packed channel data; channel k occupies bits [k*BITS +: BITS]
validIn  input  CANALES  per-channel request / data valid
readyIn  output  CANALES  per-channel accept; at most one bit high per cycle
modo  input  1  0 = fixed select, 1 = round-robin
selDato  input  SEL_W  channel index used when modo=0
datoOutput  output  BITS  registered selected data
validOut  output  1  datoOutput holds an unconsumed word
readyOut  input  1  consumer accepts datoOutput
canalOut  output  SEL_W  index of channel that produced datoOutput

Behaviour:
- Reset (rst=1 at clk edge):
  - validOut=0, datoOutput=0, canalOut=0.
  - Round-robin pointer ptr=CANALES-1, so channel 0 has first priority.
  - rst overrides any handshake in the same cycle. A word in flight is dropped.
- Output stage is a single register, states VACIO (validOut=0) and LLENO (validOut=1).
- carga = !validOut | readyOut. Combinational; readyOut passes through to readyIn in the same cycle.
- Grant (combinational, evaluated every cycle):
  - modo=0: gnt=selDato; hay = validIn[selDato].
  - modo=0, selDato >= CANALES: hay=0, no grant.
  - modo=1: gnt = first k with validIn[k]=1, searching ptr+1, ptr+2, ... modulo CANALES (wraps CANALES-1 -> 0). hay = |validIn.
- readyIn[gnt] = carga & hay. All other readyIn bits = 0. readyIn does not depend on validIn of non-granted channels.
- Transfer in: carga & hay at edge:
  - datoOutput <= datoIn[gnt].
  - canalOut <= gnt.
  - validOut <= 1.
  - If modo=1: ptr <= gnt. In modo=0, ptr is unchanged.
- Transfer out: validOut & readyOut at edge consumes the word. If no transfer in happens in the same cycle, validOut <= 0. A simultaneous consume and load keeps validOut=1 with the new word, giving full throughput of 1 word/cycle.
- No transfer: datoOutput and canalOut hold. They also hold while validOut=0; stale values are permitted.
- Latency: input accepted at edge n appears on datoOutput/validOut after edge n (1 cycle).
- Stall: validOut=1 & readyOut=0. All readyIn=0, output stable, ptr stable.
- Switching modo takes effect on the next grant evaluation. No word is lost or duplicated. ptr is retained across mode changes.
- Fairness (modo=1, all channels continuously valid, readyOut=1): grants cycle 0,1,...,CANALES-1,0. Each channel is granted exactly once per CANALES transfers.
- Non-power-of-2 CANALES: wrap uses modulo CANALES. Unused index codes are never granted.

Test Plan:
- Reset, then modo=0, selDato=5, validIn=16'h0020, datoIn[5]=32'hCAFE0005, readyOut=1. Expect: readyIn=16'h0020 the same cycle; next cycle datoOutput=32'hCAFE0005, canalOut=5, validOut=1.
- modo=0, selDato=3, validIn[3]=0, other channels valid. Expect: readyIn=0, validOut stays 0.
- modo=1, validIn=16'hFFFF held, readyOut=1, datoIn[k]=k for 20 cycles. Expect: canalOut sequence 0,1,...,15,0,1,2,3, validOut=1 every cycle.
- modo=1, validIn=16'h8001, readyOut=1. Expect: grants alternate 0,15,0,15. Then drop readyOut for 3 cycles: output frozen, readyIn=0, ptr unchanged. Then raise readyOut: the next grant resumes the alternation.
- Back-pressure: load a word, hold readyOut=0 with new validIn pending. Expect: datoOutput unchanged, no readyIn. Raise readyOut for one cycle: the old word is consumed and the new word loaded in the same edge, validOut stays 1.
- Assert rst while validOut=1 and ptr=7. Expect: next cycle validOut=0, datoOutput=0, canalOut=0. The first round-robin grant afterwards goes to channel 0.
- Parameter sweep CANALES=5, BITS=8, modo=1, all valid. Expect: canalOut sequence 0,1,2,3,4,0. Drive selDato=6 in modo=0: no grant.
